// File: rtl/sim_step_ctrl.sv
// -----------------------------------------------------------------------------
// sim_step_ctrl
// Simulation-step controller for the real-time turbine model. Advances the
// step index sim_time once every STEP_CYC cycles and pulses step_start at the
// first cycle of each step. It tracks the solver's step_done handshake, waits
// for late solvers and sets a sticky overrun flag when a deadline is missed.
//
// Parameters:
//   TIME_W    width of sim_time
//   STEP_CYC  clock cycles per nominal step (>= 4)
//   END_TIME  last step index executed before entering DONE
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   start       pulse: begin a run from sim_time = 0 (IDLE/DONE only)
//   stop        pulse: abort to IDLE, wins over start
//   pause       level: hold at the next step boundary while high
//   step_done   pulse from solver: current step finished
//   sim_time    index of the step currently executing
//   step_start  pulse on the first cycle of every step
//   running     high in RUN and WAIT
//   done        high in DONE
//   overrun     sticky deadline-miss flag, cleared by start
//   ovr_count   (SIM_STEP_OVRCNT_EN only) saturating count of steps that
//               entered WAIT, cleared by reset and start
//
// Optional feature macro: SIM_STEP_OVRCNT_EN
// -----------------------------------------------------------------------------
module sim_step_ctrl #(
    parameter int unsigned       TIME_W   = 32,
    parameter int unsigned       STEP_CYC = 100,
    parameter logic [TIME_W-1:0] END_TIME = {TIME_W{1'b1}}
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic              pause,
    input  logic              step_done,
    output logic [TIME_W-1:0] sim_time,
    output logic              step_start,
    output logic              running,
    output logic              done,
    output logic              overrun
`ifdef SIM_STEP_OVRCNT_EN
    ,
    output logic [15:0]       ovr_count
`endif
);

    localparam int unsigned CNT_W = (STEP_CYC > 1) ? $clog2(STEP_CYC) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STEP_CYC - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RUN   = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_PAUSE = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              done_seen_q, done_seen_d;
    logic [TIME_W-1:0] sim_time_q, sim_time_d;
    logic              step_start_q, step_start_d;
    logic              running_q, running_d;
    logic              done_q, done_d;
    logic              overrun_q, overrun_d;
    logic              boundary;
    logic              next_step;
`ifdef SIM_STEP_OVRCNT_EN
    logic [15:0]       ovr_count_q, ovr_count_d;
`endif

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            done_seen_q  <= 1'b0;
            sim_time_q   <= '0;
            step_start_q <= 1'b0;
            running_q    <= 1'b0;
            done_q       <= 1'b0;
            overrun_q    <= 1'b0;
`ifdef SIM_STEP_OVRCNT_EN
            ovr_count_q  <= '0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            done_seen_q  <= done_seen_d;
            sim_time_q   <= sim_time_d;
            step_start_q <= step_start_d;
            running_q    <= running_d;
            done_q       <= done_d;
            overrun_q    <= overrun_d;
`ifdef SIM_STEP_OVRCNT_EN
            ovr_count_q  <= ovr_count_d;
`endif
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        done_seen_d  = done_seen_q;
        sim_time_d   = sim_time_q;
        step_start_d = 1'b0;
        overrun_d    = overrun_q;
        boundary     = 1'b0;
        next_step    = 1'b0;
`ifdef SIM_STEP_OVRCNT_EN
        ovr_count_d  = ovr_count_q;
`endif

        if (stop) begin
            // sim_time deliberately holds so downstream sees the last index
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_d      = S_RUN;
                        sim_time_d   = '0;
                        cnt_d        = '0;
                        done_seen_d  = 1'b0;
                        overrun_d    = 1'b0;
                        step_start_d = 1'b1;
`ifdef SIM_STEP_OVRCNT_EN
                        ovr_count_d  = '0;
`endif
                    end
                end
                S_RUN: begin
                    if (step_done) begin
                        done_seen_d = 1'b1;
                    end
                    if (cnt_q == LAST_CNT) begin
                        // completion in the last cycle still meets the deadline
                        if (done_seen_q || step_done) begin
                            boundary = 1'b1;
                        end else begin
                            state_d   = S_WAIT;
                            overrun_d = 1'b1;
`ifdef SIM_STEP_OVRCNT_EN
                            if (ovr_count_q != 16'hFFFF) begin
                                ovr_count_d = ovr_count_q + 16'd1;
                            end
`endif
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_WAIT: begin
                    if (step_done) begin
                        boundary = 1'b1;
                    end
                end
                S_PAUSE: begin
                    if (!pause) begin
                        state_d   = S_RUN;
                        next_step = 1'b1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase

            // Step boundary: END_TIME takes priority over pause
            if (boundary) begin
                cnt_d       = '0;
                done_seen_d = 1'b0;
                if (sim_time_q == END_TIME) begin
                    state_d = S_DONE;
                end else if (pause) begin
                    state_d = S_PAUSE;
                end else begin
                    state_d   = S_RUN;
                    next_step = 1'b1;
                end
            end

            if (next_step) begin
                sim_time_d   = sim_time_q + TIME_W'(1);
                cnt_d        = '0;
                done_seen_d  = 1'b0;
                step_start_d = 1'b1;
            end
        end

        running_d = (state_d == S_RUN) || (state_d == S_WAIT);
        done_d    = (state_d == S_DONE);
    end

    assign sim_time   = sim_time_q;
    assign step_start = step_start_q;
    assign running    = running_q;
    assign done       = done_q;
    assign overrun    = overrun_q;
`ifdef SIM_STEP_OVRCNT_EN
    assign ovr_count  = ovr_count_q;
`endif

endmodule

// File: tb/tb_sim_step_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sim_step_ctrl
// Directed bench for sim_step_ctrl with STEP_CYC=8, END_TIME=3: normal run,
// boundary coincidence, overrun/WAIT, pause, start/stop collision, ignored
// start in RUN and asynchronous reset in WAIT.
// -----------------------------------------------------------------------------
module tb_sim_step_ctrl;

    localparam int unsigned TIME_W   = 32;
    localparam int unsigned STEP_CYC = 8;
    localparam logic [TIME_W-1:0] END_TIME = 32'd3;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic              stop;
    logic              pause;
    logic              step_done;
    logic [TIME_W-1:0] sim_time;
    logic              step_start;
    logic              running;
    logic              done;
    logic              overrun;
`ifdef SIM_STEP_OVRCNT_EN
    logic [15:0]       ovr_count;
`endif

    int checks   = 0;
    int failures = 0;

    sim_step_ctrl #(
        .TIME_W   (TIME_W),
        .STEP_CYC (STEP_CYC),
        .END_TIME (END_TIME)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .stop       (stop),
        .pause      (pause),
        .step_done  (step_done),
        .sim_time   (sim_time),
        .step_start (step_start),
        .running    (running),
        .done       (done),
        .overrun    (overrun)
`ifdef SIM_STEP_OVRCNT_EN
        ,
        .ovr_count  (ovr_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk1(input string tag, input logic got, input logic exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%b exp=%b", tag, got, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one clock and sample 1 time unit after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Run one full step starting at cnt=0; step_done asserted in cycle done_at
    // (done_at >= STEP_CYC means no step_done during the step)
    task automatic run_step(input int done_at);
        for (int j = 0; j < int'(STEP_CYC); j++) begin
            if (j == done_at) step_done = 1'b1;
            tick();
            step_done = 1'b0;
            if (j == 3) begin
                chk1("mid_step_start", step_start, 1'b0);
                chk1("mid_running", running, 1'b1);
            end
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        stop      = 1'b0;
        pause     = 1'b0;
        step_done = 1'b0;

        // Reset state
        tick();
        tick();
        chk32("rst_sim_time", sim_time, 32'd0);
        chk1("rst_step_start", step_start, 1'b0);
        chk1("rst_running", running, 1'b0);
        chk1("rst_done", done, 1'b0);
        chk1("rst_overrun", overrun, 1'b0);
        rst_n = 1'b1;
        tick();
        tick();
        chk1("idle_no_step_start", step_start, 1'b0);
        chk1("idle_running", running, 1'b0);

        // Normal run: 4 steps, step_done 3 cycles after each step_start
        start = 1'b1;
        tick();
        start = 1'b0;
        chk1("n0_step_start", step_start, 1'b1);
        chk1("n0_running", running, 1'b1);
        chk32("n0_sim_time", sim_time, 32'd0);
        for (int s = 1; s <= 3; s++) begin
            run_step(3);
            chk1("n_step_start", step_start, 1'b1);
            chk32("n_sim_time", sim_time, 32'(s));
        end
        run_step(3);
        chk1("n_done", done, 1'b1);
        chk1("n_done_running", running, 1'b0);
        chk1("n_done_step_start", step_start, 1'b0);
        chk32("n_done_sim_time", sim_time, 32'd3);
        chk1("n_overrun", overrun, 1'b0);
        tick();
        tick();
        chk1("done_hold", done, 1'b1);
        chk1("done_no_step_start", step_start, 1'b0);
        chk32("done_sim_time_hold", sim_time, 32'd3);

        // Restart from DONE; step 0 completes exactly on the last cycle
        start = 1'b1;
        tick();
        start = 1'b0;
        chk1("r_step_start", step_start, 1'b1);
        chk1("r_done_clear", done, 1'b0);
        chk32("r_sim_time", sim_time, 32'd0);
        run_step(7);
        chk1("coinc_step_start", step_start, 1'b1);
        chk32("coinc_sim_time", sim_time, 32'd1);
        chk1("coinc_overrun", overrun, 1'b0);
`ifdef SIM_STEP_OVRCNT_EN
        chk32("coinc_ovr_count", 32'(ovr_count), 32'd0);
`endif

        // Overrun: step 1 finishes in cycle 11
        run_step(99);
        chk1("wait_overrun", overrun, 1'b1);
        chk1("wait_running", running, 1'b1);
        chk1("wait_step_start", step_start, 1'b0);
        chk32("wait_sim_time", sim_time, 32'd1);
        tick();
        tick();
        tick();
        chk1("wait_still_no_start", step_start, 1'b0);
        step_done = 1'b1;
        tick();
        step_done = 1'b0;
        chk1("ovr_step_start", step_start, 1'b1);
        chk32("ovr_sim_time", sim_time, 32'd2);
        chk1("ovr_sticky", overrun, 1'b1);
`ifdef SIM_STEP_OVRCNT_EN
        chk32("ovr_count", 32'(ovr_count), 32'd1);
`endif

        // Pause during step 2
        pause = 1'b1;
        run_step(3);
        chk1("pause_step_start", step_start, 1'b0);
        chk32("pause_sim_time", sim_time, 32'd2);
        chk1("pause_running", running, 1'b0);
        tick();
        tick();
        chk1("pause_hold_step_start", step_start, 1'b0);
        chk32("pause_hold_sim_time", sim_time, 32'd2);
        pause = 1'b0;
        tick();
        chk1("resume_step_start", step_start, 1'b1);
        chk32("resume_sim_time", sim_time, 32'd3);
        chk1("resume_running", running, 1'b1);

        // start and stop together in RUN: stop wins
        tick();
        tick();
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        chk1("stop_running", running, 1'b0);
        chk1("stop_step_start", step_start, 1'b0);
        chk1("stop_done", done, 1'b0);
        chk32("stop_sim_time_hold", sim_time, 32'd3);
        tick();
        chk1("stop_idle_no_start", step_start, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk1("s2_step_start", step_start, 1'b1);
        chk32("s2_sim_time", sim_time, 32'd0);
        chk1("s2_overrun_clear", overrun, 1'b0);
`ifdef SIM_STEP_OVRCNT_EN
        chk32("s2_ovr_count_clear", 32'(ovr_count), 32'd0);
`endif

        // start while in RUN is ignored (now at cnt=1 then cnt=2)
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk1("ign_start_step_start", step_start, 1'b0);
        chk32("ign_start_sim_time", sim_time, 32'd0);

        // Reach WAIT (cnt=2 -> 6 more cycles) without step_done
        for (int k = 0; k < 6; k++) tick();
        chk1("w2_overrun", overrun, 1'b1);
        chk1("w2_running", running, 1'b1);

        // Asynchronous reset mid-cycle in WAIT
        #3;
        rst_n = 1'b0;
        #1;
        chk32("arst_sim_time", sim_time, 32'd0);
        chk1("arst_step_start", step_start, 1'b0);
        chk1("arst_running", running, 1'b0);
        chk1("arst_done", done, 1'b0);
        chk1("arst_overrun", overrun, 1'b0);
        tick();
        chk1("arst_hold_step_start", step_start, 1'b0);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk1("post_rst_no_step_start", step_start, 1'b0);
        end
        chk1("post_rst_running", running, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sim_step_ctrl.md
# sim_step_ctrl

Simulation-step controller for the wind-turbine real-time model. Produces the simulation time index `sim_time` and a per-step start strobe at a fixed clock-cycle period, and tracks the solver pipeline's step-completion handshake. Sits directly upstream of every stage that keys behaviour off `sim_time`, including the torque-initialisation hold stage and the electrical/mechanical solvers. Flags steps where the solver misses its real-time deadline.

## Interface
- `TIME_W`, 32, width of `sim_time`; equals the global `WIDTH_TIME`.
- `STEP_CYC`, 100, clock cycles per simulation step; minimum 4.
- `END_TIME`, 32'hFFFF_FFFF, last step index executed before DONE.

- `clk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse; begins a run from `sim_time`=0.
- `stop`  in  1  one-cycle pulse; aborts the run and returns to IDLE.
- `pause`  in  1  level; holds at the next step boundary while high.
- `step_done`  in  1  one-cycle pulse from the solver: current step finished.
- `sim_time`  out  TIME_W  index of the step currently executing.
- `step_start`  out  1  one-cycle pulse at the first cycle of each step.
- `running`  out  1  high in RUN and WAIT.
- `done`  out  1  high in DONE.
- `overrun`  out  1  sticky; set when a step exceeds STEP_CYC cycles.

## Operation
- States: IDLE, RUN, WAIT, PAUSE, DONE. Reset enters IDLE.
- Internal registers: period counter `cnt` (0..STEP_CYC-1) and `done_seen` flag.
- IDLE: `start` -> RUN; `sim_time`<=0, `cnt`<=0, `overrun`<=0, `step_start` pulses.
- RUN: `cnt` increments each cycle. `step_done` sets `done_seen`. When `cnt`==STEP_CYC-1:
  - `done_seen` or `step_done` this cycle, and `sim_time`==END_TIME -> DONE.
  - `done_seen` or `step_done` this cycle, and `pause` high -> PAUSE.
  - `done_seen` or `step_done` this cycle, otherwise -> RUN; `sim_time`+1, `cnt`<=0, `done_seen`<=0, `step_start` pulses.
  - No completion -> WAIT; `overrun`<=1.
- WAIT: on `step_done`, apply the same END_TIME/pause/next-step decision as RUN, with the next step starting the following cycle.
- PAUSE: `sim_time` holds. `pause` low -> RUN with `sim_time`+1 and a `step_start` pulse.
- DONE: `sim_time` holds END_TIME; no `step_start`. `start` restarts as from IDLE.
- `stop` in any state -> IDLE; `sim_time` holds its last value until the next `start`.
- `stop` and `start` in the same cycle: `stop` wins.
- `step_done` in IDLE, PAUSE or DONE is ignored.
- A second `step_done` within one step is ignored.
- `start` while in RUN, WAIT or PAUSE is ignored.
- `sim_time` increments without saturation logic. END_TIME bounds it, so no wrap occurs.

## Timing
- Reset values: `sim_time`=0, `step_start`=0, `running`=0, `done`=0, `overrun`=0, state IDLE.
- All outputs are registered.
- `start` sampled at cycle t: `step_start`=1 and `running`=1 at t+1 with `sim_time`=0.
- Nominal step period is exactly STEP_CYC cycles between `step_start` pulses.
- `sim_time` changes in the same cycle that `step_start` is high.
- Overrun: `step_done` sampled at cycle t in WAIT -> next `step_start` at t+1.
- `done` rises one cycle after the final boundary decision.
- Reset asserted mid-step clears everything immediately (asynchronous); `step_start` is never emitted during reset.

## Configuration
- `SIM_STEP_OVRCNT_EN` defined:
  - Adds output `ovr_count` [15:0]: counts steps that entered WAIT.
  - Saturates at 16'hFFFF; cleared by reset and by `start`.
- Not defined: the port and counter are absent; only the sticky `overrun` flag exists.

## Test plan
- Normal run: STEP_CYC=8, END_TIME=3; `start`, then `step_done` 3 cycles after each `step_start` -> 4 `step_start` pulses 8 cycles apart, `sim_time` 0..3, then `done`=1 with `sim_time`=3, `overrun`=0.
- Overrun: in step 1, withhold `step_done` until cycle 11 of the step -> WAIT entered, `overrun`=1, next `step_start` one cycle after `step_done`, `sim_time`=2; with the macro, `ovr_count`=1.
- Pause: `pause` high during step 2 -> held at `sim_time`=2 with no `step_start`; `pause` low -> `step_start` next cycle with `sim_time`=3.
- Boundary coincidence: `step_done` exactly on `cnt`==7 -> no WAIT, `overrun` stays 0.
- Stop/start collision: `start` and `stop` together while in RUN -> IDLE, `running`=0; a later `start` gives `sim_time`=0 and clears `overrun`.
- Async reset: assert `rst_n`=0 in WAIT mid-cycle -> all outputs 0 immediately; after release, no `step_start` until `start`.
